fbank_lut_sched: RTL and testbench

FBANK_LUT_SCHED -- requirements
Module: fbank_lut_sched

---
 rtl/fbank_lut_sched.sv | 159 +++++++++++++++
 tb/tb_fbank_lut_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fbank_lut_sched.sv
// Filter-bank coefficient scheduler: arbitrates host writes into the single-port
// coefficient RAM and streams one sweep of coefficients to the filter engine
// through a 2-entry FIFO under ready/valid flow control.
// ram_addr is the RAM's address register: ram_rd_data reflects ram_addr in the
// cycle it is presented, and it is captured at the end of that cycle.
module fbank_lut_sched #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 17,
  parameter int unsigned N_COEF     = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  input  logic                  host_wr_req,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  output logic                  host_wr_ack,
  output logic                  coef_valid,
  input  logic                  coef_ready,
  output logic [DATA_WIDTH-1:0] coef_data,
  output logic [ADDR_WIDTH-1:0] coef_idx,
  output logic                  coef_last,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_wr_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  typedef enum logic [1:0] {IDLE, WRITE, RUN, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_COEF - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   rd_cnt;
  logic                    rd_pend;
  logic                    skid_valid;
  logic [DATA_WIDTH-1:0]   skid_data;
  logic [ADDR_WIDTH-1:0]   skid_idx;
  logic                    skid_last;
  logic                    pop;
  logic                    flush;
  logic [1:0]              credit_used;
  logic                    can_issue;

  assign busy = (state != IDLE);
  assign pop  = coef_valid & coef_ready;

  // Credit check: entries held plus the read landing this edge, less the pop.
  always_comb begin
    credit_used = 2'(coef_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(pop);
    can_issue   = (credit_used < 2'd2);
    flush       = abort && ((state == RUN) || (state == DRAIN));
  end

  // Sequencer: host writes, read issue, drain and completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_cnt      <= '0;
      rd_pend     <= 1'b0;
      done        <= 1'b0;
      host_wr_ack <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
    end else begin
      done        <= 1'b0;
      host_wr_ack <= 1'b0;
      ram_wr_en   <= 1'b0;
      rd_pend     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            rd_cnt <= '0;
          end else if (host_wr_req) begin
            state       <= WRITE;
            ram_wr_en   <= 1'b1;
            host_wr_ack <= 1'b1;
            ram_addr    <= host_wr_addr;
            ram_wr_data <= host_wr_data;
          end
        end
        WRITE: state <= IDLE;
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (can_issue) begin
            ram_addr <= rd_cnt;
            rd_pend  <= 1'b1;
            if (rd_cnt == LAST_ADDR) state <= DRAIN;
            else                     rd_cnt <= rd_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
          end else if (pop && coef_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry FIFO: the head drives coef_*, the skid entry backs it up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_valid <= 1'b0;
      coef_data  <= '0;
      coef_idx   <= '0;
      coef_last  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_idx   <= '0;
      skid_last  <= 1'b0;
    end else if (flush) begin
      coef_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (pop) begin
      if (skid_valid) begin
        coef_data <= skid_data;
        coef_idx  <= skid_idx;
        coef_last <= skid_last;
        if (rd_pend) begin
          skid_data <= ram_rd_data;
          skid_idx  <= ram_addr;
          skid_last <= (ram_addr == LAST_ADDR);
        end else begin
          skid_valid <= 1'b0;
        end
      end else if (rd_pend) begin
        coef_data <= ram_rd_data;
        coef_idx  <= ram_addr;
        coef_last <= (ram_addr == LAST_ADDR);
      end else begin
        coef_valid <= 1'b0;
      end
    end else if (rd_pend) begin
      if (!coef_valid) begin
        coef_valid <= 1'b1;
        coef_data  <= ram_rd_data;
        coef_idx   <= ram_addr;
        coef_last  <= (ram_addr == LAST_ADDR);
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= ram_rd_data;
        skid_idx   <= ram_addr;
        skid_last  <= (ram_addr == LAST_ADDR);
      end
    end
  end

endmodule

// File: tb/tb_fbank_lut_sched.sv
// Bench for fbank_lut_sched: RAM models, a reference coefficient table and a
// per-cycle stream checker driven with randomized backpressure.
module tb_fbank_lut_sched;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 17;
  localparam int unsigned N  = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          start1 = 1'b0;
  logic          abort = 1'b0;
  logic          host_wr_req = 1'b0;
  logic [AW-1:0] host_wr_addr = '0;
  logic [DW-1:0] host_wr_data = '0;
  logic          coef_ready = 1'b0;

  logic          busy, done, host_wr_ack, coef_valid, coef_last, ram_wr_en;
  logic [DW-1:0] coef_data, ram_wr_data, ram_rd_data;
  logic [AW-1:0] coef_idx, ram_addr;

  logic          busy1, done1, host_wr_ack1, coef_valid1, coef_last1, ram_wr_en1;
  logic [DW-1:0] coef_data1, ram_wr_data1, ram_rd_data1;
  logic [AW-1:0] coef_idx1, ram_addr1;

  logic [DW-1:0] ram0    [N];
  logic [DW-1:0] ram1    [N];
  logic [DW-1:0] mem_ref [N];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  fbank_lut_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_COEF(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_wr_ack(host_wr_ack), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_data(coef_data), .coef_idx(coef_idx), .coef_last(coef_last),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .ram_rd_data(ram_rd_data)
  );

  fbank_lut_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_COEF(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .busy(busy1), .done(done1),
    .host_wr_req(host_wr_req), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_wr_ack(host_wr_ack1), .coef_valid(coef_valid1), .coef_ready(coef_ready),
    .coef_data(coef_data1), .coef_idx(coef_idx1), .coef_last(coef_last1),
    .ram_addr(ram_addr1), .ram_wr_data(ram_wr_data1), .ram_wr_en(ram_wr_en1),
    .ram_rd_data(ram_rd_data1)
  );

  // Coefficient RAMs: write on the clock, read data follows the address register.
  always @(posedge clk) begin
    if (ram_wr_en)  ram0[ram_addr]  <= ram_wr_data;
    if (ram_wr_en1) ram1[ram_addr1] <= ram_wr_data1;
  end
  assign ram_rd_data  = ram0[ram_addr];
  assign ram_rd_data1 = ram1[ram_addr1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit full_chk);
    int unsigned waited = 0;
    host_wr_req  = 1'b1;
    host_wr_addr = a;
    host_wr_data = d;
    do begin
      @(negedge clk);
      waited++;
    end while (!host_wr_ack && waited < 20);
    if (full_chk) begin
      check("wr_ack_latency", waited, 32'd1);
      check("wr_en", 32'(ram_wr_en), 32'd1);
      check("wr_addr", 32'(ram_addr), 32'(a));
      check("wr_data", 32'(ram_wr_data), 32'(d));
      check("wr_busy", 32'(busy), 32'd1);
    end else if (!host_wr_ack) begin
      check("wr_timeout", 32'd0, 32'd1);
    end
    host_wr_req = 1'b0;
    mem_ref[a]  = d;
    @(negedge clk);
    if (full_chk) begin
      check("wr_en_drop", 32'(ram_wr_en), 32'd0);
      check("wr_ack_drop", 32'(host_wr_ack), 32'd0);
      check("wr_busy_drop", 32'(busy), 32'd0);
    end
  endtask

  // One sweep on the N-coefficient instance; optional abort or reset at an index.
  task automatic run_sweep(input int unsigned stall_pct, input int abort_idx, input int rst_idx);
    int unsigned   exp_idx = 0;
    int unsigned   cyc = 0;
    bit            prev_stall = 0, done_due = 0, seen_valid = 0, abort_due = 0, fin = 0;
    logic [DW-1:0] p_data = '0;
    logic [AW-1:0] p_idx = '0;
    logic          p_last = 1'b0;
    int            outst;
    start = 1'b1;
    while (!fin) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      check("no_ack_in_sweep", 32'(host_wr_ack), 32'd0);
      if (abort_due) begin
        check("abort_valid", 32'(coef_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        abort = 1'b0;
        fin = 1;
      end else if (done_due) begin
        check("done_pulse", 32'(done), 32'd1);
        check("done_idle", 32'(busy), 32'd0);
        check("beats", exp_idx, N);
        fin = 1;
      end else begin
        check("done_early", 32'(done), 32'd0);
        check("busy_sweep", 32'(busy), 32'd1);
        if (coef_valid) begin
          if (!seen_valid) begin
            check("first_valid_cyc", cyc, 32'd3);
            seen_valid = 1;
          end
          if (prev_stall) begin
            check("stall_data", 32'(coef_data), 32'(p_data));
            check("stall_idx", 32'(coef_idx), 32'(p_idx));
            check("stall_last", 32'(coef_last), 32'(p_last));
          end
          if (exp_idx >= N) begin
            check("extra_beat", 32'd1, 32'd0);
          end else begin
            check("idx", 32'(coef_idx), exp_idx);
            check("data", 32'(coef_data), 32'(mem_ref[exp_idx]));
            check("last", 32'(coef_last), 32'(exp_idx == N - 1));
          end
        end
        if (exp_idx > 0) begin
          outst = int'(ram_addr) + 1 - int'(exp_idx);
          check("credit", 32'(outst >= 0 && outst <= 2), 32'd1);
        end
        coef_ready = ($urandom_range(99) >= stall_pct);
        if (rst_idx >= 0 && coef_valid && int'(coef_idx) == rst_idx) begin
          #2 rst_n = 1'b0;
          #1;
          check("rst_flags", 32'({busy, done, host_wr_ack, coef_valid, coef_last, ram_wr_en}), 32'd0);
          check("rst_idx", 32'(coef_idx), 32'd0);
          check("rst_cdata", 32'(coef_data), 32'd0);
          check("rst_raddr", 32'(ram_addr), 32'd0);
          check("rst_wdata", 32'(ram_wr_data), 32'd0);
          @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          check("post_rst_busy", 32'(busy), 32'd0);
          check("post_rst_valid", 32'(coef_valid), 32'd0);
          check("post_rst_done", 32'(done), 32'd0);
          fin = 1;
        end else begin
          if (abort_idx >= 0 && coef_valid && int'(coef_idx) == abort_idx) begin
            abort      = 1'b1;
            coef_ready = 1'b0;
            abort_due  = 1;
          end
          if (coef_valid && coef_ready) begin
            if (coef_last) done_due = 1;
            exp_idx++;
          end
          prev_stall = coef_valid && !coef_ready;
          p_data = coef_data;
          p_idx  = coef_idx;
          p_last = coef_last;
          if (cyc > 5000) begin
            check("sweep_timeout", 32'd0, 32'd1);
            fin = 1;
          end
        end
      end
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    int unsigned   c1, beats1, done_cyc;

    repeat (3) @(negedge clk);
    check("reset_flags", 32'({busy, done, host_wr_ack, coef_valid, coef_last, ram_wr_en}), 32'd0);
    check("reset_idx", 32'(coef_idx), 32'd0);
    check("reset_data", 32'(coef_data), 32'd0);
    check("reset_raddr", 32'(ram_addr), 32'd0);
    check("reset_wdata", 32'(ram_wr_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    host_write(AW'(5), 17'h1ABCD, 1);
    abort = 1'b1;
    host_write(AW'(6), 17'h00123, 1);
    abort = 1'b0;

    for (int i = 0; i < int'(N); i++) host_write(AW'(i), DW'(i), 0);

    coef_ready = 1'b1;
    run_sweep(0, -1, -1);
    run_sweep(50, -1, -1);

    for (int k = 0; k < 12; k++) begin
      a = (k == 0) ? '0 : AW'($urandom_range(N - 1));
      host_write(a, DW'($urandom), 0);
    end
    run_sweep(50, -1, -1);

    run_sweep(0, 300, -1);
    @(negedge clk);
    check("abort_no_late_done", 32'(done), 32'd0);
    run_sweep(0, -1, -1);

    host_wr_req  = 1'b1;
    host_wr_addr = AW'(9);
    host_wr_data = 17'h0F00D;
    run_sweep(30, -1, -1);
    host_write(AW'(9), 17'h0F00D, 1);

    host_wr_req  = 1'b1;
    host_wr_addr = AW'(3);
    host_wr_data = 17'h1FFFF;
    @(posedge clk);
    #1;
    check("midwr_ack", 32'(host_wr_ack), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midwr_rst_ack", 32'(host_wr_ack), 32'd0);
    check("midwr_rst_en", 32'(ram_wr_en), 32'd0);
    host_wr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midwr_idle", 32'(busy), 32'd0);
    check("midwr_no_ack", 32'(host_wr_ack), 32'd0);

    run_sweep(40, -1, 500);
    run_sweep(0, -1, -1);

    c1 = 0;
    beats1 = 0;
    done_cyc = 0;
    start1 = 1'b1;
    coef_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      start1 = 1'b0;
      c1++;
      if (coef_valid1) begin
        beats1++;
        check("n1_valid_cyc", c1, 32'd3);
        check("n1_idx", 32'(coef_idx1), 32'd0);
        check("n1_last", 32'(coef_last1), 32'd1);
        check("n1_data", 32'(coef_data1), 32'(mem_ref[0]));
      end
      if (done1) done_cyc = c1;
    end
    check("n1_beats", beats1, 32'd1);
    check("n1_done_cyc", done_cyc, 32'd4);
    check("n1_idle", 32'(busy1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
